// File: rtl/out_channel_checker_if.sv
// Out-channel handshake between a word producer (master) and the checker (slave).
// A word transfers on any rising clock edge where out_valid and out_ready are both high.
interface out_channel_checker_if #(
    parameter int MemoryElementWidth = 12
);
    logic                          out_valid;
    logic [MemoryElementWidth-1:0] out_data;
    logic                          out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/out_channel_checker.sv
// Buffers words from an out channel and compares them, in order, against a preloaded table.
// It reports completion, overall success and the index of the first mismatching word.
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut  = 4,
    parameter int NFifo = 4,
    localparam int IdxW = (NOut > 1) ? $clog2(NOut) : 1,
    localparam int CntW = $clog2(NOut) + 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_we,
    input  logic [IdxW-1:0]               exp_index,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic                          start,
    out_channel_checker_if.slave          out_ch,
    input  logic                          drain_en,
    output logic                          finished,
    output logic                          success,
    output logic [CntW-1:0]               mismatch_index,
    output logic [CntW-1:0]               received
);

    localparam int PtrW = (NFifo > 1) ? $clog2(NFifo) : 1;
    localparam int FcW  = $clog2(NFifo) + 1;

    localparam logic [CntW-1:0] NOutCount = CntW'(NOut);
    localparam logic [FcW-1:0]  FifoFull  = FcW'(NFifo);
    localparam logic [PtrW-1:0] LastSlot  = PtrW'(NFifo - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                        state;
    logic [MemoryElementWidth-1:0] table_mem [NOut];
    logic [MemoryElementWidth-1:0] fifo_mem  [NFifo];
    logic [PtrW-1:0]               wr_ptr;
    logic [PtrW-1:0]               rd_ptr;
    logic [FcW-1:0]                fifo_count;

    logic                          push;
    logic                          pop;
    logic [MemoryElementWidth-1:0] head_word;
    logic [MemoryElementWidth-1:0] exp_word;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == LastSlot) ? '0 : p + 1'b1;
    endfunction

    // Readiness depends only on registered state, so a word accepted this cycle
    // can never be popped before the next one.
    assign out_ch.out_ready = (state == RUN) && (fifo_count < FifoFull);
    assign push             = out_ch.out_valid && out_ch.out_ready;
    assign pop              = (state == RUN) && (fifo_count != '0) && drain_en
                              && (received < NOutCount);

    assign head_word = fifo_mem[rd_ptr];
    assign exp_word  = table_mem[received[IdxW-1:0]];

    // NOTE: storage arrays have no reset; they are only ever read after being
    // written, and leaving them unreset keeps them mappable onto RAM.
    always_ff @(posedge clock) begin
        if (exp_we && (state == IDLE)) begin
            table_mem[exp_index] <= exp_data;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= out_ch.out_data;
        end
    end

    // NOTE: all state here uses non-blocking assignment so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            received       <= '0;
            mismatch_index <= NOutCount;
            finished       <= 1'b0;
            success        <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        wr_ptr         <= '0;
                        rd_ptr         <= '0;
                        fifo_count     <= '0;
                        received       <= '0;
                        mismatch_index <= NOutCount;
                        finished       <= 1'b0;
                        success        <= 1'b0;
                    end
                end

                RUN: begin
                    if (push) begin
                        wr_ptr <= next_ptr(wr_ptr);
                    end

                    if (pop) begin
                        rd_ptr   <= next_ptr(rd_ptr);
                        received <= received + 1'b1;
                        // Only the first differing word is recorded.
                        if ((head_word != exp_word) && (mismatch_index == NOutCount)) begin
                            mismatch_index <= received;
                        end
                    end

                    if (push && !pop) begin
                        fifo_count <= fifo_count + 1'b1;
                    end else if (pop && !push) begin
                        fifo_count <= fifo_count - 1'b1;
                    end

                    if (received == NOutCount) begin
                        state    <= DONE;
                        finished <= 1'b1;
                        success  <= (mismatch_index == NOutCount);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_count_bounded: assert property (@(posedge clock) disable iff (reset)
        fifo_count <= FifoFull);

    a_pop_not_empty: assert property (@(posedge clock) disable iff (reset)
        pop |-> (fifo_count != '0));

    a_received_bounded: assert property (@(posedge clock) disable iff (reset)
        received <= NOutCount);

    a_idle_not_ready: assert property (@(posedge clock) disable iff (reset)
        (state != RUN) |-> !out_ch.out_ready);

endmodule
